// File: rtl/ocra1_rx.sv
// OCRA1 DAC serial-link receiver: oversamples the four-channel SPI stream, deframes 24-bit
// words, decodes DAC/control writes and loads the output codes on a falling edge of ldacn.
module ocra1_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        oc1_clk_i,
    input  logic        oc1_syncn_i,
    input  logic        oc1_ldacn_i,
    input  logic        oc1_sdox_i,
    input  logic        oc1_sdoy_i,
    input  logic        oc1_sdoz_i,
    input  logic        oc1_sdoz2_i,
    output logic [23:0] wordx_o,
    output logic [23:0] wordy_o,
    output logic [23:0] wordz_o,
    output logic [23:0] wordz2_o,
    output logic        word_valid_o,
    output logic        frame_err_o,
    output logic [17:0] voutx_o,
    output logic [17:0] vouty_o,
    output logic [17:0] voutz_o,
    output logic [17:0] voutz2_o,
    output logic        ldac_o,
    output logic [3:0]  out_en_o
);

    localparam int unsigned NumIn = 7;

    typedef enum logic {StIdle, StShift} state_e;

    // Bit order: {sdoz2, sdoz, sdoy, sdox, ldacn, syncn, sclk}
    logic [NumIn-1:0]                  pins;
    logic [SYNC_STAGES-1:0][NumIn-1:0] sync_q;
    logic [NumIn-1:0]                  dly_q;
    logic [NumIn-1:0]                  last;
    logic [3:0]                        sdo;

    logic sclk_fall_q, sync_fall_q, sync_rise_q, ldac_fall_q;

    state_e           state_q;
    logic [4:0]       cnt_q;
    logic [3:0][23:0] shift_q;
    logic [3:0][23:0] word_q;
    logic [3:0][17:0] inr_q;
    logic [3:0][17:0] vout_q;
    logic [3:0]       en_q;
    logic             word_valid_q, frame_err_q, ldac_q;

    assign pins = {oc1_sdoz2_i, oc1_sdoz_i, oc1_sdoy_i, oc1_sdox_i,
                   oc1_ldacn_i, oc1_syncn_i, oc1_clk_i};
    assign last = sync_q[SYNC_STAGES-1];
    // The delay stage holds the sdo value seen at the sclk-fall detection cycle.
    assign sdo  = dly_q[6:3];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            dly_q  <= '1;
        end else begin
            sync_q[0] <= pins;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_fall_q <= 1'b0;
            sync_fall_q <= 1'b0;
            sync_rise_q <= 1'b0;
            ldac_fall_q <= 1'b0;
        end else begin
            sclk_fall_q <= dly_q[0] & ~last[0];
            sync_fall_q <= dly_q[1] & ~last[1];
            sync_rise_q <= ~dly_q[1] & last[1];
            ldac_fall_q <= dly_q[2] & ~last[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            inr_q        <= '0;
            vout_q       <= '0;
            en_q         <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ldac_q       <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ldac_q       <= 1'b0;
            // Loads the pre-decode input registers when coincident with a frame end.
            if (ldac_fall_q) begin
                vout_q <= inr_q;
                ldac_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (sync_fall_q) begin
                        state_q <= StShift;
                        cnt_q   <= '0;
                        shift_q <= '0;
                    end
                end
                StShift: begin
                    if (sync_rise_q) begin
                        state_q <= StIdle;
                        if (cnt_q == 5'd24) begin
                            word_valid_q <= 1'b1;
                            word_q       <= shift_q;
                            for (int c = 0; c < 4; c++) begin
                                if (shift_q[c][23:20] == 4'h1) begin
                                    inr_q[c] <= shift_q[c][19:2];
                                end else if (shift_q[c][23:20] == 4'h2) begin
                                    en_q[c] <= ~shift_q[c][2] & ~shift_q[c][3];
                                end
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sclk_fall_q) begin
                        if (cnt_q != 5'd31) begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                        for (int c = 0; c < 4; c++) begin
                            shift_q[c] <= {shift_q[c][22:0], sdo[c]};
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wordx_o      = word_q[0];
    assign wordy_o      = word_q[1];
    assign wordz_o      = word_q[2];
    assign wordz2_o     = word_q[3];
    assign voutx_o      = vout_q[0];
    assign vouty_o      = vout_q[1];
    assign voutz_o      = vout_q[2];
    assign voutz2_o     = vout_q[3];
    assign word_valid_o = word_valid_q;
    assign frame_err_o  = frame_err_q;
    assign ldac_o       = ldac_q;
    assign out_en_o     = en_q;

endmodule

// File: tb/tb_ocra1_rx.sv
// Bench for ocra1_rx: pin-level model delayed by the frame/load latency, checked every cycle,
// plus directed literal checks for each scenario.
module tb_ocra1_rx;

    localparam int S = 2;

    typedef struct packed {
        logic [3:0][23:0] word;
        logic [3:0][17:0] inr;
        logic [3:0][17:0] vout;
        logic [3:0]       en;
        logic             wv;
        logic             fe;
        logic             ld;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b1, syncn = 1'b1, ldacn = 1'b1;
    logic [3:0] sdo = 4'h0;

    logic [23:0] wordx, wordy, wordz, wordz2;
    logic [17:0] voutx, vouty, voutz, voutz2;
    logic        word_valid, frame_err, ldac;
    logic [3:0]  out_en;

    int checks = 0;
    int errors = 0;
    int nvalid = 0, nerr = 0, nldac = 0;
    bit seen_rst = 1'b0;

    snap_t exp_s;
    snap_t q[$];

    always #4 clk = ~clk;

    ocra1_rx #(.SYNC_STAGES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .oc1_clk_i    (sclk),
        .oc1_syncn_i  (syncn),
        .oc1_ldacn_i  (ldacn),
        .oc1_sdox_i   (sdo[0]),
        .oc1_sdoy_i   (sdo[1]),
        .oc1_sdoz_i   (sdo[2]),
        .oc1_sdoz2_i  (sdo[3]),
        .wordx_o      (wordx),
        .wordy_o      (wordy),
        .wordz_o      (wordz),
        .wordz2_o     (wordz2),
        .word_valid_o (word_valid),
        .frame_err_o  (frame_err),
        .voutx_o      (voutx),
        .vouty_o      (vouty),
        .voutz_o      (voutz),
        .voutz2_o     (voutz2),
        .ldac_o       (ldac),
        .out_en_o     (out_en)
    );

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Model: pin events at each sampling edge, results emerge S+1 edges later.
    initial begin
        snap_t st;
        bit active;
        int cnt;
        logic [3:0][23:0] sh;
        logic p_sclk, p_sync, p_ldac;
        st = '0; active = 0; cnt = 0; sh = '0;
        p_sclk = 1; p_sync = 1; p_ldac = 1;
        exp_s = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                st = '0; active = 0; cnt = 0; sh = '0;
                p_sclk = 1; p_sync = 1; p_ldac = 1;
                q.delete();
                for (int i = 0; i < S + 1; i++) q.push_back('0);
                exp_s = '0;
                seen_rst = 1'b1;
            end else begin
                st.wv = 0; st.fe = 0; st.ld = 0;
                if (p_ldac && !ldacn) begin
                    st.vout = st.inr;
                    st.ld = 1;
                end
                if (!active) begin
                    if (p_sync && !syncn) begin
                        active = 1; cnt = 0; sh = '0;
                    end
                end else if (!p_sync && syncn) begin
                    active = 0;
                    if (cnt == 24) begin
                        st.wv = 1;
                        st.word = sh;
                        for (int c = 0; c < 4; c++) begin
                            if (sh[c][23:20] == 4'h1) st.inr[c] = sh[c][19:2];
                            else if (sh[c][23:20] == 4'h2) st.en[c] = !sh[c][2] && !sh[c][3];
                        end
                    end else begin
                        st.fe = 1;
                    end
                end else if (p_sclk && !sclk) begin
                    cnt++;
                    for (int c = 0; c < 4; c++) sh[c] = {sh[c][22:0], sdo[c]};
                end
                q.push_back(st);
                exp_s = q.pop_front();
                p_sclk = sclk; p_sync = syncn; p_ldac = ldacn;
            end
        end
    end

    // Cycle compare and pulse counting.
    initial begin
        logic [3:0][23:0] dw;
        logic [3:0][17:0] dv;
        forever begin
            @(negedge clk);
            if (seen_rst) begin
                dw = {wordz2, wordz, wordy, wordx};
                dv = {voutz2, voutz, vouty, voutx};
                for (int c = 0; c < 4; c++) begin
                    check($sformatf("word%0d", c), dw[c], exp_s.word[c]);
                    check($sformatf("vout%0d", c), {6'h0, dv[c]}, {6'h0, exp_s.vout[c]});
                end
                check("out_en", {20'h0, out_en}, {20'h0, exp_s.en});
                check("word_valid", {23'h0, word_valid}, {23'h0, exp_s.wv});
                check("frame_err", {23'h0, frame_err}, {23'h0, exp_s.fe});
                check("ldac", {23'h0, ldac}, {23'h0, exp_s.ld});
                if (word_valid === 1'b1) nvalid++;
                if (frame_err === 1'b1) nerr++;
                if (ldac === 1'b1) nldac++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [23:0] dac(input logic [17:0] code);
        return {4'h1, code, 2'b00};
    endfunction

    // mode 0: normal end, 1: ldacn falls with syncn rise, 2: reset instead of frame end
    task automatic send_frame(input logic [3:0][23:0] w, input int nbits, input int mode);
        syncn = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < 4; c++) sdo[c] = (i < 24) ? w[c][23-i] : 1'b0;
            tick(4);
            sclk = 1'b0;
            tick(4);
            sclk = 1'b1;
        end
        tick(4);
        if (mode == 2) begin
            rst = 1'b1;
            tick(1);
            syncn = 1'b1;
            tick(3);
            rst = 1'b0;
            tick(8);
        end else begin
            syncn = 1'b1;
            if (mode == 1) ldacn = 1'b0;
            tick(4);
            ldacn = 1'b1;
            tick(8);
        end
    endtask

    task automatic pulse_ldac();
        ldacn = 1'b0;
        tick(4);
        ldacn = 1'b1;
        tick(8);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_wordx", wordx, 24'h0);
        check("rst_voutx", {6'h0, voutx}, 24'h0);
        check("rst_out_en", {20'h0, out_en}, 24'h0);
        check("rst_pulses", nvalid + nerr + nldac, 24'h0);

        send_frame({4{24'h200002}}, 24, 0);
        check("ctl_nvalid", nvalid, 24'd1);
        check("ctl_wordx", wordx, 24'h200002);
        check("ctl_wordz2", wordz2, 24'h200002);
        check("ctl_out_en", {20'h0, out_en}, 24'hF);
        check("ctl_voutx", {6'h0, voutx}, 24'h0);
        check("ctl_nldac", nldac, 24'd0);

        send_frame({dac(18'd4), dac(18'd3), dac(18'd2), dac(18'd1)}, 24, 0);
        check("ld_pre_voutx", {6'h0, voutx}, 24'h0);
        check("ld_wordy", wordy, 24'h100008);
        pulse_ldac();
        check("ld_voutx", {6'h0, voutx}, 24'd1);
        check("ld_vouty", {6'h0, vouty}, 24'd2);
        check("ld_voutz", {6'h0, voutz}, 24'd3);
        check("ld_voutz2", {6'h0, voutz2}, 24'd4);
        check("ld_nldac", nldac, 24'd1);

        send_frame({dac(18'h3FFFC), dac(18'h3FFFD), dac(18'h3FFFE), dac(18'h3FFFF)}, 24, 0);
        pulse_ldac();
        check("neg_voutx", {6'h0, voutx}, 24'h3FFFF);
        check("neg_vouty", {6'h0, vouty}, 24'h3FFFE);
        check("neg_voutz", {6'h0, voutz}, 24'h3FFFD);
        check("neg_voutz2", {6'h0, voutz2}, 24'h3FFFC);

        send_frame({4{dac(18'd5)}}, 23, 0);
        check("t23_nerr", nerr, 24'd1);
        check("t23_nvalid", nvalid, 24'd3);
        check("t23_wordx", wordx, 24'h1FFFFC);
        pulse_ldac();
        check("t23_voutx", {6'h0, voutx}, 24'h3FFFF);
        send_frame({4{dac(18'd5)}}, 25, 0);
        check("t25_nerr", nerr, 24'd2);
        check("t25_nvalid", nvalid, 24'd3);
        pulse_ldac();
        check("t25_voutz2", {6'h0, voutz2}, 24'h3FFFC);

        send_frame({4{24'h100004}}, 12, 2);
        check("mrst_nerr", nerr, 24'd2);
        check("mrst_nvalid", nvalid, 24'd3);
        check("mrst_voutx", {6'h0, voutx}, 24'h0);
        check("mrst_out_en", {20'h0, out_en}, 24'h0);
        send_frame({4{24'h100004}}, 24, 0);
        check("post_wordx", wordx, 24'h100004);
        check("post_nvalid", nvalid, 24'd4);
        pulse_ldac();
        check("post_voutx", {6'h0, voutx}, 24'd1);
        check("post_voutz2", {6'h0, voutz2}, 24'd1);

        send_frame({dac(18'd9), dac(18'd8), dac(18'd7), dac(18'd6)}, 24, 1);
        check("sim_voutx", {6'h0, voutx}, 24'd1);
        check("sim_nldac", nldac, 24'd6);
        check("sim_wordx", wordx, 24'h100018);
        pulse_ldac();
        check("sim2_voutx", {6'h0, voutx}, 24'd6);
        check("sim2_voutz2", {6'h0, voutz2}, 24'd9);
        check("sim2_nldac", nldac, 24'd7);

        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
